// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and
// elaboration-time helpers for digit count and counter width.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit slots per operand; guarded so a bad DIGIT cannot divide by zero.
  function automatic int calc_ndig(input int width, input int digit);
    if (digit < 1) begin
      return 1;
    end
    return width / digit;
  endfunction

  function automatic int calc_cnt_w(input int ndig);
    if (ndig <= 1) begin
      return 1;
    end
    return $clog2(ndig);
  endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple slice; also exposes the carry into its MSB
// so the caller can derive signed overflow on the final digit.
module adder_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      full_adder u_fa (
        .i_a  (x[gi]),
        .i_b  (y[gi]),
        .i_ci (w_c[gi]),
        .o_s  (s[gi]),
        .o_co (w_c[gi+1])
      );
    end
  endgenerate

  assign co    = w_c[DIGIT];
  assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the digit slice.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic w_p;

  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & w_p);

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds WIDTH-bit operands plus carry-in over WIDTH/DIGIT
// cycles through one shared DIGIT-bit slice, with valid/ready on both sides.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $fatal(1, "digit_serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_run_last;
  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_sum_shift;

  adder_digit #(
    .DIGIT (DIGIT)
  ) u_slice (
    .x     (r_a[DIGIT-1:0]),
    .y     (r_b[DIGIT-1:0]),
    .ci    (r_carry),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_c_msb)
  );

  // New digit enters at the top; after NDIG shifts the first digit sits at bit 0.
  generate
    if (NDIG == 1) begin : g_single
      assign w_sum_shift = w_s;
    end else begin : g_multi
      assign w_sum_shift = {w_s, r_sum[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_accept   = in_valid && in_ready;
  assign w_run_last = (r_state == RUN) && (r_cnt == LAST_CNT);

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_sum   <= '0;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_carry <= w_co;
        r_sum   <= w_sum_shift;
        if (w_run_last) begin
          r_cout <= w_co;
          r_ovf  <= w_c_msb ^ w_co;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench: table vectors, corner sequences and randomized
// transactions on three parameterisations against an arithmetic model.
module tb_digit_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid   [3];
  logic       out_ready  [3];
  logic [7:0] a_s        [3];
  logic [7:0] b_s        [3];
  logic       cin_s      [3];
  logic       in_ready_w [3];
  logic       out_valid_w[3];
  logic       cout_w     [3];
  logic       ovf_w      [3];
  logic [7:0] sum_w      [3];
  logic [7:0] sum82, sum88;
  logic [5:0] sum63;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         stall;
    bit         disturb;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d82 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready[0]), .sum(sum82), .cout(cout_w[0]), .overflow(ovf_w[0])
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d88 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready[1]), .sum(sum88), .cout(cout_w[1]), .overflow(ovf_w[1])
  );

  digit_serial_adder #(.WIDTH(6), .DIGIT(3)) u_d63 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .a(a_s[2][5:0]), .b(b_s[2][5:0]), .cin(cin_s[2]), .out_valid(out_valid_w[2]),
    .out_ready(out_ready[2]), .sum(sum63), .cout(cout_w[2]), .overflow(ovf_w[2])
  );

  assign sum_w[0] = sum82;
  assign sum_w[1] = sum88;
  assign sum_w[2] = {2'b00, sum63};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  function automatic int width_of(input int d);
    return (d == 2) ? 6 : 8;
  endfunction

  function automatic int ndig_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 2);
  endfunction

  // Reference: plain unsigned and signed arithmetic over the operand width.
  task automatic model(input int w, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, output logic [7:0] s, output logic co,
                       output logic ov);
    int ua, ub, full, sa, sb, ss;
    ua   = int'(a) % (1 << w);
    ub   = int'(b) % (1 << w);
    full = ua + ub + int'(cin);
    s    = 8'(full % (1 << w));
    co   = (full >= (1 << w));
    sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    ss   = sa + sb + int'(cin);
    ov   = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One full handshake transaction on DUT d, entered and left at a negedge.
  task automatic run_txn(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input int stall, input bit disturb,
                         input logic [7:0] es, input logic ec, input logic eo);
    int w;
    int lat;
    w = 0;
    while (!in_ready_w[d] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_idle", 32'(in_ready_w[d]), 32'd1);
    in_valid[d]  = 1'b1;
    a_s[d]       = a;
    b_s[d]       = b;
    cin_s[d]     = cin;
    out_ready[d] = (stall == 0);
    @(negedge clk);
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid_w[d] && lat < 50) begin
      if (disturb) begin
        a_s[d]   = 8'($urandom);
        b_s[d]   = 8'($urandom);
        cin_s[d] = 1'($urandom);
      end
      if (in_ready_w[d]) begin
        chk("in_ready_run", 32'(in_ready_w[d]), 32'd0);
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(ndig_of(d)));
    chk("sum", 32'(sum_w[d]), 32'(es));
    chk("cout", 32'(cout_w[d]), 32'(ec));
    chk("overflow", 32'(ovf_w[d]), 32'(eo));
    chk("in_ready_done", 32'(in_ready_w[d]), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid_w[d]), 32'd1);
      chk("hold_sum", 32'(sum_w[d]), 32'(es));
      chk("hold_in_ready", 32'(in_ready_w[d]), 32'd0);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(out_valid_w[d]), 32'd0);
    chk("release_in_ready", 32'(in_ready_w[d]), 32'd1);
    $display("txn dut=%0d a=%02h b=%02h cin=%0d stall=%0d sum=%02h cout=%0d ovf=%0d lat=%0d",
             d, a, b, cin, stall, sum_w[d], cout_w[d], ovf_w[d], lat);
  endtask

  task automatic run_random(input int d, input int n);
    logic [7:0] a, b, es;
    logic       cin, ec, eo;
    int         w;
    w = width_of(d);
    for (int i = 0; i < n; i++) begin
      a   = 8'($urandom_range(0, (1 << w) - 1));
      b   = 8'($urandom_range(0, (1 << w) - 1));
      cin = 1'($urandom);
      model(w, a, b, cin, es, ec, eo);
      run_txn(d, a, b, cin, int'($urandom_range(0, 2)), bit'($urandom), es, ec, eo);
    end
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0] es;
    logic       ec, eo;
    int         ready_cnt, res_cnt;

    vecs[0] = '{8'h3C, 8'h5A, 1'b0, 0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h00, 1'b1, 0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b1, 3, 1'b0, 8'h47, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 0, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 1, 1'b1, 8'h01, 1'b0, 1'b0};

    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      a_s[d]       = 8'h00;
      b_s[d]       = 8'h00;
      cin_s[d]     = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", 32'(in_ready_w[d]), 32'd1);
      chk("rst_out_valid", 32'(out_valid_w[d]), 32'd0);
      chk("rst_sum", 32'(sum_w[d]), 32'd0);
      chk("rst_cout", 32'(cout_w[d]), 32'd0);
      chk("rst_overflow", 32'(ovf_w[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_txn(0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall, vecs[i].disturb,
              vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
    end

    // Reset in the middle of RUN must clear outputs without a clock edge.
    in_valid[0] = 1'b1;
    a_s[0] = 8'hAB; b_s[0] = 8'hCD; cin_s[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid_w[0]), 32'd0);
    chk("midrst_in_ready", 32'(in_ready_w[0]), 32'd1);
    chk("midrst_sum", 32'(sum_w[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 32'(in_ready_w[0]), 32'd1);
    $display("txn dut=0 reset mid-run in_ready=%0d out_valid=%0d sum=%02h",
             in_ready_w[0], out_valid_w[0], sum_w[0]);
    run_txn(0, 8'h01, 8'h01, 1'b0, 0, 1'b0, 8'h02, 1'b0, 1'b0);

    // in_valid held across DONE->IDLE: back-to-back accepts every NDIG+2 cycles.
    ready_cnt = 0;
    res_cnt   = 0;
    in_valid[0] = 1'b1;
    a_s[0] = 8'h11; b_s[0] = 8'h22; cin_s[0] = 1'b0;
    out_ready[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (in_ready_w[0] && in_valid[0]) ready_cnt++;
      if (out_valid_w[0]) begin
        res_cnt++;
        if (res_cnt == 1) begin
          chk("b2b_first_cycle", 32'(k), 32'd5);
          chk("b2b_sum1", 32'(sum_w[0]), 32'h33);
          a_s[0] = 8'hF0; b_s[0] = 8'h20; cin_s[0] = 1'b1;
        end else begin
          chk("b2b_second_cycle", 32'(k), 32'd11);
          model(8, 8'hF0, 8'h20, 1'b1, es, ec, eo);
          chk("b2b_sum2", 32'(sum_w[0]), 32'(es));
          chk("b2b_cout2", 32'(cout_w[0]), 32'(ec));
          in_valid[0] = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("b2b_accepts", 32'(ready_cnt), 32'd2);
    chk("b2b_results", 32'(res_cnt), 32'd2);
    $display("txn dut=0 back-to-back accepts=%0d results=%0d", ready_cnt, res_cnt);

    run_random(0, 60);
    run_random(1, 60);
    run_random(2, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised successor to the team's combinational full adder and 2-bit ripple adder.
- Adds two WIDTH-bit operands plus carry-in over WIDTH/DIGIT clock cycles, DIGIT bits per cycle, using one DIGIT-bit adder slice.
- Valid/ready handshake on input and output, so it sits between a producer and consumer in the datapath where area matters more than latency.
- Also reports carry-out and signed overflow.

Parameters:
- WIDTH, 8: operand and sum width in bits; must be ≥ 1.
- DIGIT, 2: bits added per cycle; must divide WIDTH exactly (elaboration-time check, fatal on violation).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands and cin are valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum, cout and overflow are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, FSM=IDLE, digit counter=0, internal carry=0.
- Constant: NDIG = WIDTH/DIGIT.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at a rising edge: capture a, b, cin into shift registers, clear the sum register, set counter=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge: the slice adds the low DIGIT bits of the A/B shift registers plus the carry register.
  - Result digit shifts into the top of the sum register, from the LSB digit upward. A/B registers shift right by DIGIT. Carry register updates. Counter increments.
  - On the edge where counter==NDIG-1: latch cout = slice carry-out, latch overflow = slice MSB carry-in XOR slice carry-out, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and overflow are held stable while out_ready=0.
  - On out_ready=1 at an edge: go to IDLE and drop out_valid.
- Latency: out_valid rises exactly NDIG edges after the accepting edge.
- Throughput: one result per NDIG+2 cycles when out_ready is held at 1. No overlap: in_ready is 0 during RUN and DONE.
- Inputs a, b, cin are ignored outside the accepting edge; changes during RUN must not affect the result.
- out_ready is ignored outside DONE.
- in_valid held high across DONE→IDLE: the new operands are accepted on the first IDLE edge.
- DIGIT==WIDTH: NDIG=1, one RUN cycle, behaves as a registered adder.
- Counter width is $clog2(NDIG) with a minimum of 1; it never wraps past NDIG-1.
- Reset mid-operation (rst_n low in RUN or DONE): all outputs go to reset values immediately, without waiting for a clock edge. The partial result is discarded. in_ready=1 on the first cycle after release.
- sum/cout/overflow keep their last values in IDLE; the consumer uses them only when out_valid=1.

Decomposition:
- Shared package adder_pkg: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), helper function computing NDIG and counter width.
- One sub-module, adder_digit: combinational DIGIT-bit ripple slice built from the existing full-adder cell.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, c_msb (carry into the slice MSB).
- digit_serial_adder contains only the FSM, counter, shift registers and carry register.

Test Plan (WIDTH=8, DIGIT=2 unless stated):
- a=0x3C, b=0x5A, cin=0, out_ready=1 → out_valid high exactly 4 edges after accept; sum=0x96, cout=0, overflow=1.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0, overflow=1.
- Backpressure: a=0x12, b=0x34, cin=1, out_ready=0 for 3 cycles in DONE → out_valid stays 1, sum=0x47 stable, in_ready=0. Release → IDLE next edge.
- Input disturbance: toggle a/b/cin randomly during RUN after accepting a=0x80, b=0x80, cin=0 → sum=0x00, cout=1, overflow=1.
- Reset mid-run: assert rst_n=0 at RUN count 2 → out_valid=0, in_ready=1, sum=0 immediately. Next accept of a=0x01, b=0x01 → sum=0x02.
- Parameter sweep: WIDTH=8, DIGIT=8 (latency 1) and WIDTH=6, DIGIT=3 (latency 2) over exhaustive/random operands versus a reference model; latency and all outputs must match.
